// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate self-test sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gate_test_pkg;

  // Sequencer states: IDLE waits for start, APPLY holds a vector while the gate settles,
  // SAMPLE compares the gate output, DONE pulses the end-of-run indication.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Truth tables for 4-input gates; bit v is the expected output for input vector v.
  localparam logic [15:0] TT_AND4  = 16'h8000;
  localparam logic [15:0] TT_OR4   = 16'hFFFE;
  localparam logic [15:0] TT_NAND4 = 16'h7FFF;
  localparam logic [15:0] TT_NOR4  = 16'h0001;
  localparam logic [15:0] TT_XOR4  = 16'h6996;

endpackage

// File: rtl/gate_test_sequencer_settle_timer.sv
// Load/count-down timer that measures the settle time of one applied vector.
// Latency: expired is high in the SETTLE_CYC-th enabled cycle after a load.
// Backpressure: none; load always wins over counting.
module settle_timer #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  // Loaded with SETTLE_CYC-1 so that the count reaches zero in the last settle cycle.
  localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYC - 1);

  logic [W-1:0] cnt;

  // Reload on each new vector, then count down to zero while enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Walks a gate through all 2^N_IN input vectors and checks its output against EXPECT_TT.
// Latency: done pulses 1 + 2^N_IN*(SETTLE_CYC+1) cycles after the start edge.
// Backpressure: none; start is only accepted in IDLE and ignored otherwise (no queuing).
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int                      N_IN       = 4,
  parameter int                      SETTLE_CYC = 2,
  parameter logic [(1<<N_IN)-1:0]    EXPECT_TT  = TT_AND4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            gate_out,
  output logic [N_IN-1:0] gate_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  state_t          state;
  state_t          state_nxt;
  logic [N_IN-1:0] vec;
  logic            timer_load;
  logic            timer_en;
  logic            timer_expired;
  logic            mismatch;
  logic            accept;

  settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  assign mismatch = (gate_out != EXPECT_TT[vec]);
  assign accept   = (state == IDLE) && start;
  assign gate_in  = vec;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, timer control and status outputs.
  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = APPLY;
          timer_load = 1'b1;
        end
      end
      APPLY: begin
        busy     = 1'b1;
        timer_en = 1'b1;
        if (timer_expired) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        busy = 1'b1;
        if (vec == VEC_LAST) begin
          state_nxt = DONE;
        end else begin
          state_nxt  = APPLY;
          timer_load = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Vector counter and result registers; pass is resolved on the last SAMPLE edge so it is
  // already valid while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec            <= '0;
      fail_count     <= '0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else if (accept) begin
      vec            <= '0;
      fail_count     <= '0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else if (state == SAMPLE) begin
      if (mismatch) begin
        fail_count <= fail_count + (N_IN+1)'(1);
        if (fail_count == '0) begin
          first_fail_vec <= vec;
        end
      end
      if (vec == VEC_LAST) begin
        pass <= (fail_count == '0) && !mismatch;
      end else begin
        vec <= vec + N_IN'(1);
      end
    end
  end

endmodule
